// File: rtl/sprite_arb_pkg.sv
// Shared defaults and types for the sprite ROM arbiter and its round-robin picker.
package sprite_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 15;
  localparam int DW_DEF   = 4;
  localparam int CNT_W    = 16;

  typedef logic [NREQ_DEF-1:0] req_vec_t;

  // Width of an index into NREQ requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or above ptr_i,
// wrapping from NREQ-1 back to 0. Produces both one-hot and binary forms.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    logic [IW-1:0] j;
    j        = '0;
    any_o    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between NREQ pixel pipelines.
// Optional per-requester grant counters are built when SPRITE_ARB_STATS_EN is defined.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_q,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            en_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [NREQ-1:0] id_q [ROM_LAT];

  logic [NREQ-1:0] masked_req, pick_req, pick_oh;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;

  // A requester still sees its own gnt this cycle and has not dropped req yet,
  // so it is masked out unless nobody else is asking.
  assign masked_req = req & ~gnt_q;
  assign pick_req   = (masked_req != '0) ? masked_req : req;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (pick_req),
    .ptr_i    (ptr_q),
    .any_o    (pick_any),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    gnt_d  = pick_oh;
    addr_d = '0;
    ptr_d  = ptr_q;
    if (pick_any) begin
      addr_d = req_addr[int'(pick_idx)*AW +: AW];
      ptr_d  = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
    end
    if (frame_start) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      en_q   <= pick_any;
      addr_q <= addr_d;
      // Grant ID rides alongside the ROM read so the response lands on its owner.
      id_q[0] <= gnt_q;
      for (int k = 1; k < ROM_LAT; k++) begin
        id_q[k] <= id_q[k-1];
      end
    end
  end

  assign gnt       = gnt_q;
  assign rom_en    = en_q;
  assign rom_addr  = addr_q;
  assign rsp_valid = id_q[ROM_LAT-1];
  assign rsp_data  = (rsp_valid != '0) ? rom_q : '0;

`ifdef SPRITE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (frame_start) begin
          cnt_q[i] <= {{(CNT_W-1){1'b0}}, gnt_d[i]};
        end else if (gnt_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a ROM_LAT=1 instance under full scoreboard
// checking, plus a ROM_LAT=2 instance on the same inputs for reset-flush behaviour.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam int NREQ = NREQ_DEF;
  localparam int AW   = AW_DEF;
  localparam int DW   = DW_DEF;
  localparam int LAT1 = 1;
  localparam int GW   = NREQ + AW + DW;
  localparam int RW   = 32 + NREQ + DW;

  logic               vga_clk = 1'b0;
  logic               reset;
  logic               frame_start;
  req_vec_t           req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt1, gnt2, rsp_valid1, rsp_valid2;
  logic               rom_en1, rom_en2;
  logic [AW-1:0]      rom_addr1, rom_addr2;
  logic [DW-1:0]      rom_q1, rom_q2, rsp_data1, rsp_data2;
`ifdef SPRITE_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt1, grant_cnt2;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pushed   = 0;
  int rsp2_cnt = 0;
  int win2_cnt = 0;
  bit win2     = 1'b0;
  int issued  [NREQ] = '{default: 0};
  int granted [NREQ] = '{default: 0};

  logic [GW-1:0] exp_gnt_q[$];
  logic [RW-1:0] exp_rsp_q[$];
  logic [DW-1:0] rom1_q;
  logic [DW-1:0] rom2_q [2];

  // ---------------- clock / reset ----------------
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs and ROM models ----------------
  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt1),
    .rom_en      (rom_en1),
    .rom_addr    (rom_addr1),
    .rom_q       (rom_q1),
    .rsp_valid   (rsp_valid1),
    .rsp_data    (rsp_data1)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt1)
`endif
  );

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(2)) u_dut2 (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_start (frame_start),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt2),
    .rom_en      (rom_en2),
    .rom_addr    (rom_addr2),
    .rom_q       (rom_q2),
    .rsp_valid   (rsp_valid2),
    .rsp_data    (rsp_data2)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt2)
`endif
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[DW-1:0] + 4'h6;
  endfunction

  always @(posedge vga_clk) begin
    rom1_q    <= rom_fn(rom_addr1);
    rom2_q[0] <= rom_fn(rom_addr2);
    rom2_q[1] <= rom2_q[0];
  end
  assign rom_q1 = rom1_q;
  assign rom_q2 = rom2_q[1];

  // Requesters hold req until every issued read has been granted.
  always_comb begin
    req = '0;
    for (int i = 0; i < NREQ; i++) req[i] = (issued[i] != granted[i]);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic issue(input int i, input int n, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
    issued[i] += n;
  endtask

  task automatic push(input logic [NREQ-1:0] oh, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_gnt_q.push_back({oh, a, d});
    pushed++;
  endtask

  task automatic expect_seq(input string name, input logic [NREQ-1:0] oh);
    tick();
    check(name, gnt1, oh);
  endtask

  function automatic int busy_cnt();
    int b = exp_gnt_q.size() + exp_rsp_q.size();
    for (int i = 0; i < NREQ; i++) b += issued[i] - granted[i];
    return b;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (busy_cnt() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, busy_cnt(), 0);
    repeat (2) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [GW-1:0]   e;
    logic [RW-1:0]   r;
    logic [NREQ-1:0] oh;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [31:0]     due;
    forever begin
      @(negedge vga_clk);
      if (gnt1 != '0) begin
        for (int i = 0; i < NREQ; i++) if (gnt1[i]) granted[i]++;
        if (exp_gnt_q.size() == 0) begin
          check("gnt_unexpected", gnt1, 0);
        end else begin
          e = exp_gnt_q.pop_front();
          {oh, a, d} = e;
          check("gnt", gnt1, oh);
          check("rom_en", rom_en1, 1);
          check("rom_addr", rom_addr1, a);
          exp_rsp_q.push_back({32'(cyc + LAT1), oh, d});
        end
      end else if (rom_en1) begin
        check("rom_en_idle", rom_en1, 0);
      end
      if (rsp_valid1 != '0) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid1, 0);
        end else begin
          r = exp_rsp_q.pop_front();
          {due, oh, d} = r;
          check("rsp_valid", rsp_valid1, oh);
          check("rsp_data", rsp_data1, d);
          check("rsp_cycle", cyc, due);
        end
      end
      if (reset) exp_rsp_q.delete();
      if (rsp_valid2 != '0) begin
        rsp2_cnt++;
        if (win2) win2_cnt++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : driver
    reset       = 1'b1;
    frame_start = 1'b0;
    req_addr    = '0;
    repeat (3) tick();
    check("rst_gnt", gnt1, 0);
    check("rst_rom_en", rom_en1, 0);
    check("rst_rom_addr", rom_addr1, 0);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_rsp_data", rsp_data1, 0);

    // All four held from reset; requester 0 wants two reads.
    for (int i = 0; i < NREQ; i++) issue(i, (i == 0) ? 2 : 1, AW'(16 + i));
    push(4'b0001, 15'h0010, 4'h6);
    push(4'b0010, 15'h0011, 4'h7);
    push(4'b0100, 15'h0012, 4'h8);
    push(4'b1000, 15'h0013, 4'h9);
    push(4'b0001, 15'h0010, 4'h6);
    tick();
    check("gnt_in_reset", gnt1, 0);
    reset = 1'b0;
    expect_seq("rr_seq0", 4'b0001);
    expect_seq("rr_seq1", 4'b0010);
    expect_seq("rr_seq2", 4'b0100);
    expect_seq("rr_seq3", 4'b1000);
    expect_seq("rr_seq4", 4'b0001);
    wait_drain("rr", 50);

    // Single requester 2 (ptr=1).
    issue(2, 1, 15'h1234);
    push(4'b0100, 15'h1234, 4'hA);
    wait_drain("single", 20);

    // ptr=3, req=1001: 3 then wrap to 0.
    issue(3, 1, 15'h7FF3);
    issue(0, 1, 15'h0000);
    push(4'b1000, 15'h7FF3, 4'h9);
    push(4'b0001, 15'h0000, 4'h6);
    expect_seq("wrap3", 4'b1000);
    expect_seq("wrap0", 4'b0001);
    wait_drain("wrap", 20);

    // Move ptr to 2, then frame_start with all four requesting.
    issue(1, 1, 15'h0ABC);
    push(4'b0010, 15'h0ABC, 4'h2);
    wait_drain("to_ptr2", 20);
    for (int i = 0; i < NREQ; i++) issue(i, 1, AW'(256 + i));
    frame_start = 1'b1;
    push(4'b0100, 15'h0102, 4'h8);
    push(4'b0001, 15'h0100, 4'h6);
    push(4'b0010, 15'h0101, 4'h7);
    push(4'b1000, 15'h0103, 4'h9);
    tick();
    frame_start = 1'b0;
    check("fs_gnt2", gnt1, 4'b0100);
    expect_seq("fs_gnt0", 4'b0001);
    expect_seq("fs_gnt1", 4'b0010);
    expect_seq("fs_gnt3", 4'b1000);
    wait_drain("frame", 20);

    // Idle cycles; ptr must stay 0 so 1 wins over 3.
    repeat (4) begin
      tick();
      check("idle_gnt", gnt1, 0);
      check("idle_en", rom_en1, 0);
    end
    issue(1, 1, 15'h0201);
    issue(3, 1, 15'h0203);
    push(4'b0010, 15'h0201, 4'h7);
    push(4'b1000, 15'h0203, 4'h9);
    expect_seq("hold_1", 4'b0010);
    expect_seq("hold_3", 4'b1000);
    wait_drain("hold", 20);

    // Lone requester may be granted back-to-back.
    issue(2, 2, 15'h0007);
    push(4'b0100, 15'h0007, 4'hD);
    push(4'b0100, 15'h0007, 4'hD);
    expect_seq("solo_a", 4'b0100);
    expect_seq("solo_b", 4'b0100);
    wait_drain("solo", 20);

    // frame_start while granting 0: next grant must skip the still-high req[0].
    issue(0, 2, 15'h0020);
    issue(1, 1, 15'h0031);
    frame_start = 1'b1;
    push(4'b0001, 15'h0020, 4'h6);
    push(4'b0010, 15'h0031, 4'h7);
    push(4'b0001, 15'h0020, 4'h6);
    tick();
    frame_start = 1'b0;
    check("mask_0", gnt1, 4'b0001);
    expect_seq("mask_1", 4'b0010);
    expect_seq("mask_2", 4'b0001);
    wait_drain("mask", 20);

    // Reset one cycle after gnt[1]: the ROM_LAT=2 response must never appear.
    issue(1, 1, 15'h0321);
    push(4'b0010, 15'h0321, 4'h7);
    tick();
    check("flush_gnt2", gnt2, 4'b0010);
    win2 = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("flush_rsp2_now", rsp_valid2, 0);
    check("flush_gnt_rst", gnt1, 0);
    reset = 1'b0;
    repeat (4) tick();
    win2 = 1'b0;
    check("flush_rsp2", win2_cnt, 0);
    check("flush_sb", busy_cnt(), 0);

    // ptr back at 0 after reset: 0 before 3.
    issue(3, 1, 15'h0043);
    issue(0, 1, 15'h0040);
    push(4'b0001, 15'h0040, 4'h6);
    push(4'b1000, 15'h0043, 4'h9);
    expect_seq("post_rst_0", 4'b0001);
    expect_seq("post_rst_3", 4'b1000);
    wait_drain("post_rst", 20);

`ifdef SPRITE_ARB_STATS_EN
    issue(0, 70000, 15'h0008);
    for (int k = 0; k < 70000; k++) push(4'b0001, 15'h0008, 4'hE);
    wait_drain("stats", 80000);
    check("cnt_sat", grant_cnt1[15:0], 16'hFFFF);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("cnt_clear", grant_cnt1[15:0], 16'h0000);
`endif

    repeat (4) tick();
    check("rsp2_total", rsp2_cnt, pushed - 1);
    check("sb_empty", exp_gnt_q.size() + exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
